sigma_sched_ctrl: RTL
=====================

SIGMA_SCHED_CTRL -- requirements
Module: sigma_sched_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, datapath word width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 run  input  1  start pulse; sampled only in IDLE.
REQ-005 sig0_c0, sig0_c1, sig0_c2  input  32 each  sigma0 rotate/rotate/shift amounts; only bits [4:0] are used.
REQ-006 sig1_c0, sig1_c1, sig1_c2  input  32 each  sigma1 rotate/rotate/shift amounts; only bits [4:0] are used.
REQ-007 in_valid  input  1  load word valid.
REQ-008 in_data  input  DATA_W  load word W[0..15], in order.
REQ-009 in_ready  output  1  load word accepted when in_valid && in_ready.
REQ-010 out_valid  output  1  schedule word valid.
REQ-011 out_data  output  DATA_W  schedule word W[t], t = 0..63.
REQ-012 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse on completion.

Function
REQ-015 FSM states: IDLE, LOAD, EXPAND, DONE.
REQ-016 IDLE -> LOAD when run=1; on that edge the six sig* amounts are captured into config registers, held until the next start.
- run asserted in any state other than IDLE is ignored.
REQ-017 LOAD:
- in_ready=1;
- each accepted word is written to a 16-entry circular buffer at slot index (0..15);
- on the 16th accept, go to EXPAND with t=0.
REQ-018 in_ready=0 in every state other than LOAD.
REQ-019 Rotate and shift functions:
- sigma(x) = ROTR(x,c0) ^ ROTR(x,c1) ^ SHR(x,c2), using the captured 5-bit amounts;
- ROTR by 0 and SHR by 0 return x unchanged (no shift-by-32 term).
REQ-020 EXPAND word generation:
- t<16: the produced word is buf[t];
- t>=16: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^32;
- the result is written to buf[t mod 16] in the cycle it is produced.
REQ-021 The output register loads the next W[t] and increments t when out_valid=0 or (out_valid && out_ready); otherwise out_data and out_valid hold stable.
REQ-022 Latency and throughput:
- first out_valid=1 appears in the cycle after the 16th load accept;
- with out_ready held at 1, one word is output per cycle, 64 consecutive cycles.
REQ-023 Go to DONE when W[63] is accepted:
- out_valid=0 in DONE;
- done=1 for exactly one cycle;
- then return to IDLE.
REQ-024 Buffer reads for t>=16 come only from slots not yet overwritten by W[t] (t-2, t-7, t-15, t-16 mod 16); writes to slot t mod 16 occur after its read of W[t-16] in the same cycle.
REQ-025 Simultaneous events:
- in_valid outside LOAD is ignored;
- out_ready with out_valid=0 has no effect;
- run together with done (DONE state) is ignored.

Reset
REQ-026 On rst=0 at a clock edge:
- state=IDLE;
- t=0 and load index=0;
- out_valid=0, out_data=0, in_ready=0, busy=0, done=0;
- config registers=0.
REQ-027 Buffer contents are not reset and are never output before being rewritten in LOAD.
REQ-028 Reset asserted mid-LOAD or mid-EXPAND aborts the operation: the outputs take the REQ-026 values on the following cycle and no done pulse is produced.

Verification
REQ-029 "abc" vector:
- stimulus: amounts sig0 = 7/18/3, sig1 = 17/19/10; load W0=0x61626380, W1..W14=0, W15=0x00000018; out_ready=1;
- required response: out W0..W15 match the input; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; exactly 64 words, then a single done pulse.
REQ-030 All-zero block:
- stimulus: any amounts, 16 zero words loaded;
- required response: all 64 outputs 0x00000000; busy high from the cycle after run until done.
REQ-031 Backpressure:
- stimulus: "abc" vector; out_ready=0 for 5 cycles while W20 is presented;
- required response: out_data and out_valid hold stable; the word sequence is identical to the REQ-029 run.
REQ-032 Zero amounts:
- stimulus: all sig* amounts = 0; load W0=0x00000001, remainder 0;
- required response: W16=0x00000001, matching the reference model with sigma(x)=x.
REQ-033 Reset and run-while-busy:
- stimulus: rst=0 for 1 cycle at t=30 during EXPAND;
- required response: next cycle out_valid=0, busy=0, done=0; a subsequent run gives a correct full sequence.
- stimulus: run pulsed during LOAD;
- required response: no effect.

Source files
------------

// File: rtl/sigma_sched_ctrl_if.sv
// Purpose: load/output handshake bundle for the sigma message-schedule block.
// Latency: n/a (wiring only).
// Backpressure: in_* is valid/ready into the block; out_* is valid/ready out of it.
// Ports: in_valid/in_data/in_ready carry the 16 load words; out_valid/out_data/
//        out_ready carry the 64 schedule words. slave = block side, master = driver side.
interface sigma_sched_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sigma_sched_ctrl.sv
// Purpose: loads 16 words, then emits the 64-word sigma message schedule W[0..63].
// Latency: first word valid the cycle after the 16th load accept, then 1 word/cycle.
// Backpressure: output register holds while out_valid && !out_ready; in_ready only in LOAD.
// Ports: clk, rst (sync, active-low), run (start pulse, IDLE only),
//        sig0_c0..c2 / sig1_c0..c2 (rotate/rotate/shift amounts, bits [4:0] used),
//        io (slave modport: load + output handshakes), busy (not IDLE), done (1-cycle pulse).
module sigma_sched_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] sig0_c0,
  input  logic [DATA_W-1:0] sig0_c1,
  input  logic [DATA_W-1:0] sig0_c2,
  input  logic [DATA_W-1:0] sig1_c0,
  input  logic [DATA_W-1:0] sig1_c1,
  input  logic [DATA_W-1:0] sig1_c2,
  sigma_sched_ctrl_if.slave io,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // cfg[0..2] = sigma0 amounts, cfg[3..5] = sigma1 amounts
  logic [5:0][4:0]   cfg_q, cfg_d;
  logic [3:0]        idx_q, idx_d;
  logic [6:0]        t_q, t_d;           // index of the next word to load into the output register
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [DATA_W-1:0] buf_q [16];
  logic              buf_we;
  logic [3:0]        buf_wa;
  logic [DATA_W-1:0] buf_wd;

  logic              in_acc;
  logic              out_adv;
  logic              last_acc;
  logic [3:0]        t_lo;
  logic [DATA_W-1:0] w_m2, w_m7, w_m15, w_m16, w_next;

  // Upper amount bits are intentionally ignored.
  logic unused_amt_hi;
  assign unused_amt_hi = ^{sig0_c0[DATA_W-1:5], sig0_c1[DATA_W-1:5], sig0_c2[DATA_W-1:5],
                           sig1_c0[DATA_W-1:5], sig1_c1[DATA_W-1:5], sig1_c2[DATA_W-1:5]};

  // Amount 0 is special-cased so no shift-by-DATA_W term is ever formed.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [4:0] n);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, n};
    return (n == 5'd0) ? x : ((x >> n) | (x << inv));
  endfunction

  function automatic logic [DATA_W-1:0] sigma(input logic [DATA_W-1:0] x,
                                              input logic [4:0] a,
                                              input logic [4:0] b,
                                              input logic [4:0] c);
    return rotr(x, a) ^ rotr(x, b) ^ (x >> c);
  endfunction

  // The buffer holds W[t-16..t-1]; slot t mod 16 still holds W[t-16] when read,
  // and is overwritten with W[t] at the same edge.
  assign t_lo  = t_q[3:0];
  assign w_m2  = buf_q[t_lo - 4'd2];
  assign w_m7  = buf_q[t_lo - 4'd7];
  assign w_m15 = buf_q[t_lo - 4'd15];
  assign w_m16 = buf_q[t_lo];

  always_comb begin
    w_next = w_m16;
    if (t_q >= 7'd16) begin
      w_next = sigma(w_m2, cfg_q[3], cfg_q[4], cfg_q[5]) + w_m7
             + sigma(w_m15, cfg_q[0], cfg_q[1], cfg_q[2]) + w_m16;
    end
  end

  assign in_acc   = (state_q == S_LOAD) && io.in_valid;
  assign out_adv  = !out_valid_q || io.out_ready;
  assign last_acc = (state_q == S_EXPAND) && (t_q == 7'd64) && out_valid_q && io.out_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_LOAD;
      S_LOAD:   if (in_acc && (idx_q == 4'd15)) state_d = S_EXPAND;
      S_EXPAND: if (last_acc) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    io.in_ready = (state_q == S_LOAD);
  end

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;

  // ---------------- datapath next values ----------------
  always_comb begin
    cfg_d       = cfg_q;
    idx_d       = idx_q;
    t_d         = t_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    buf_we      = 1'b0;
    buf_wa      = idx_q;
    buf_wd      = io.in_data;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          cfg_d = {sig1_c2[4:0], sig1_c1[4:0], sig1_c0[4:0],
                   sig0_c2[4:0], sig0_c1[4:0], sig0_c0[4:0]};
          idx_d = 4'd0;
          t_d   = 7'd0;
        end
      end
      S_LOAD: begin
        if (in_acc) begin
          buf_we = 1'b1;
          idx_d  = idx_q + 4'd1;
          // On the last load, W[0] (already in slot 0) goes straight to the
          // output register so the first word appears one cycle later.
          if (idx_q == 4'd15) begin
            out_valid_d = 1'b1;
            out_data_d  = buf_q[0];
            t_d         = 7'd1;
          end
        end
      end
      S_EXPAND: begin
        if (out_adv) begin
          if (t_q < 7'd64) begin
            out_valid_d = 1'b1;
            out_data_d  = w_next;
            t_d         = t_q + 7'd1;
            if (t_q >= 7'd16) begin
              buf_we = 1'b1;
              buf_wa = t_lo;
              buf_wd = w_next;
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        out_valid_d = 1'b0;
        t_d         = 7'd0;
        idx_d       = 4'd0;
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_q       <= '0;
      idx_q       <= 4'd0;
      t_q         <= 7'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cfg_q       <= cfg_d;
      idx_q       <= idx_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Buffer is rewritten in LOAD before any read, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_wa] <= buf_wd;
    end
  end

endmodule
